// File: rtl/tron_pkg.sv
// Shared types and defaults for the Tron round sequencing logic.
// Contents:
//   game_state_t  - top-level game FSM encoding, shared with the game FSM
//   round_state_t - round sequencer FSM states
//   DEF_*         - default timing / match parameters
//   sat_inc       - saturating 4-bit score increment
package tron_pkg;

  typedef enum logic [2:0] {
    MENU          = 3'd0,
    ROUND_PAUSED  = 3'd1,
    ROUND_STARTED = 3'd2,
    BLUE_WINS     = 3'd3,
    RED_WINS      = 3'd4
  } game_state_t;

  typedef enum logic [2:0] {
    RS_IDLE       = 3'd0,
    RS_COUNTDOWN  = 3'd1,
    RS_RUN        = 3'd2,
    RS_CRASH_HOLD = 3'd3,
    RS_REPORT     = 3'd4
  } round_state_t;

  localparam int DEF_TICK_FRAMES  = 4;
  localparam int DEF_COUNT_FRAMES = 60;
  localparam int DEF_HOLD_FRAMES  = 90;
  localparam int DEF_WIN_ROUNDS   = 3;

  // Frame counter width; covers every timing parameter up to 255 frames.
  localparam int CNT_W = 8;

  localparam logic [3:0] SCORE_MAX = 4'd15;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == SCORE_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/frame_divider.sv
// Counts frame_start pulses and raises a one-cycle done pulse on the
// frame_start that brings the count to term; the count then restarts at 0.
// Ports:
//   clk         - clock
//   reset       - synchronous active-high reset
//   clear       - holds the count at 0; frame_start is ignored while high
//   frame_start - one-cycle frame pulse
//   term        - terminal count in frames (must be >= 1)
//   done        - combinational pulse, same cycle as the terminal frame_start
module frame_divider #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         frame_start,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] count;

  assign done = frame_start && !clear && (count == term - W'(1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (done) begin
      count <= '0;
    end else if (frame_start) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/round_sequencer.sv
// Sequences one Tron round: countdown, move ticks, crash adjudication,
// scoring and match-win detection. Paced by frame_start.
//
// state         | meaning
// --------------+-----------------------------------------------------
// RS_IDLE       | waiting for Game_State == ROUND_STARTED
// RS_COUNTDOWN  | countdown 3,2,1 shown, COUNT_FRAMES frames per step
// RS_RUN        | move_tick every TICK_FRAMES frames, watching crashes
// RS_CRASH_HOLD | scene frozen HOLD_FRAMES frames, then win check
// RS_REPORT     | Blue_W / Red_W held until game FSM leaves ROUND_STARTED
//
// Ports:
//   Clk, Reset (sync, active high), Reset_Game (same effect as Reset)
//   Game_State   - top-level game state (game_state_t)
//   frame_start  - one-cycle frame pulse
//   blue_crash, red_crash - collision levels, sampled only in RS_RUN
//   move_tick    - one-cycle advance pulse (one cycle after the frame)
//   countdown    - digit on screen, 0 = none
//   Reset_Round, clear_trails - one-cycle round teardown pulses
//   Blue_W, Red_W - match-win levels
//   blue_score, red_score - saturating round wins
//   round_draw   - last round was a draw, held until next RUN entry
module round_sequencer
  import tron_pkg::*;
#(
  parameter int TICK_FRAMES  = DEF_TICK_FRAMES,
  parameter int COUNT_FRAMES = DEF_COUNT_FRAMES,
  parameter int HOLD_FRAMES  = DEF_HOLD_FRAMES,
  parameter int WIN_ROUNDS   = DEF_WIN_ROUNDS
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Reset_Game,
  input  logic [2:0] Game_State,
  input  logic       frame_start,
  input  logic       blue_crash,
  input  logic       red_crash,
  output logic       move_tick,
  output logic [1:0] countdown,
  output logic       Reset_Round,
  output logic       clear_trails,
  output logic       Blue_W,
  output logic       Red_W,
  output logic [3:0] blue_score,
  output logic [3:0] red_score,
  output logic       round_draw
);

  round_state_t     state;
  logic             fresh;      // first cycle in a newly entered state
  logic [CNT_W-1:0] term;
  logic             div_clear;
  logic             div_done;
  logic             rst;
  logic             in_round;

  assign rst      = Reset | Reset_Game;
  assign in_round = (Game_State == ROUND_STARTED);

  // Holding the divider clear during the entry cycle discards a frame_start
  // that coincides with entering a state.
  assign div_clear = fresh || (state == RS_IDLE) || (state == RS_REPORT);

  always_comb begin
    term = CNT_W'(TICK_FRAMES);
    case (state)
      RS_COUNTDOWN:  term = CNT_W'(COUNT_FRAMES);
      RS_CRASH_HOLD: term = CNT_W'(HOLD_FRAMES);
      default:       term = CNT_W'(TICK_FRAMES);
    endcase
  end

  frame_divider #(.W(CNT_W)) u_div (
    .clk         (Clk),
    .reset       (rst),
    .clear       (div_clear),
    .frame_start (frame_start),
    .term        (term),
    .done        (div_done)
  );

  always_ff @(posedge Clk) begin
    if (rst) begin
      state        <= RS_IDLE;
      fresh        <= 1'b0;
      move_tick    <= 1'b0;
      countdown    <= 2'd0;
      Reset_Round  <= 1'b0;
      clear_trails <= 1'b0;
      Blue_W       <= 1'b0;
      Red_W        <= 1'b0;
      blue_score   <= 4'd0;
      red_score    <= 4'd0;
      round_draw   <= 1'b0;
    end else begin
      move_tick    <= 1'b0;
      Reset_Round  <= 1'b0;
      clear_trails <= 1'b0;
      fresh        <= 1'b0;

      case (state)
        RS_IDLE: begin
          if (in_round) begin
            state     <= RS_COUNTDOWN;
            countdown <= 2'd3;
            fresh     <= 1'b1;
          end
        end

        RS_COUNTDOWN: begin
          if (!in_round) begin
            state     <= RS_IDLE;
            countdown <= 2'd0;
            fresh     <= 1'b1;
          end else if (div_done) begin
            if (countdown == 2'd1) begin
              countdown  <= 2'd0;
              round_draw <= 1'b0;
              state      <= RS_RUN;
              fresh      <= 1'b1;
            end else begin
              countdown <= countdown - 2'd1;
            end
          end
        end

        RS_RUN: begin
          if (!in_round) begin
            state <= RS_IDLE;
            fresh <= 1'b1;
          end else if (blue_crash || red_crash) begin
            // A crash wins over a tick landing in the same cycle.
            state <= RS_CRASH_HOLD;
            fresh <= 1'b1;
            if (blue_crash && red_crash) begin
              round_draw <= 1'b1;
            end else if (blue_crash) begin
              red_score <= sat_inc(red_score);
            end else begin
              blue_score <= sat_inc(blue_score);
            end
          end else if (div_done) begin
            move_tick <= 1'b1;
          end
        end

        RS_CRASH_HOLD: begin
          if (!in_round) begin
            state <= RS_IDLE;
            fresh <= 1'b1;
          end else if (div_done) begin
            fresh <= 1'b1;
            if (blue_score >= 4'(WIN_ROUNDS)) begin
              Blue_W <= 1'b1;
              state  <= RS_REPORT;
            end else if (red_score >= 4'(WIN_ROUNDS)) begin
              Red_W <= 1'b1;
              state <= RS_REPORT;
            end else begin
              Reset_Round  <= 1'b1;
              clear_trails <= 1'b1;
              state        <= RS_IDLE;
            end
          end
        end

        RS_REPORT: begin
          if (!in_round) begin
            Blue_W <= 1'b0;
            Red_W  <= 1'b0;
            state  <= RS_IDLE;
            fresh  <= 1'b1;
          end
        end

        default: state <= RS_IDLE;
      endcase

      // Returning to the menu starts a fresh match.
      if (Game_State == MENU) begin
        blue_score <= 4'd0;
        red_score  <= 4'd0;
        round_draw <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_round_sequencer.sv
module tb_round_sequencer;

  localparam int TICK  = 4;
  localparam int COUNT = 2;
  localparam int HOLD  = 5;
  localparam int WIN   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0, reset_game = 1'b0;
  logic [2:0] game_state = 3'd0;
  logic       frame_start = 1'b0, blue_crash = 1'b0, red_crash = 1'b0;
  logic       move_tick, reset_round, clear_trails, blue_w, red_w, round_draw;
  logic [1:0] countdown;
  logic [3:0] blue_score, red_score;

  int checks = 0;
  int errors = 0;

  // Reference model: match-level bookkeeping only.
  int exp_blue = 0, exp_red = 0;
  bit exp_draw = 1'b0;
  int run_frames = 0;
  bit last_win = 1'b0;

  always #5 clk = ~clk;

  round_sequencer #(
    .TICK_FRAMES(TICK), .COUNT_FRAMES(COUNT), .HOLD_FRAMES(HOLD), .WIN_ROUNDS(WIN)
  ) dut (
    .Clk(clk), .Reset(reset), .Reset_Game(reset_game), .Game_State(game_state),
    .frame_start(frame_start), .blue_crash(blue_crash), .red_crash(red_crash),
    .move_tick(move_tick), .countdown(countdown), .Reset_Round(reset_round),
    .clear_trails(clear_trails), .Blue_W(blue_w), .Red_W(red_w),
    .blue_score(blue_score), .red_score(red_score), .round_draw(round_draw)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    game_state = 3'd2;
    frame_start = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    frame_start = 1'b0;
    game_state = 3'd1;
    checks++;
    if ({move_tick, countdown, reset_round, clear_trails, blue_w, red_w, round_draw} !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {move_tick, countdown, reset_round, clear_trails, blue_w, red_w, round_draw});
    end
    checks++;
    if ({blue_score, red_score} !== 8'd0) begin
      errors++;
      $display("FAIL reset_scores got %0d/%0d want 0/0", blue_score, red_score);
    end
  endtask

  // Starts a round from IDLE and walks the countdown; returns in the RUN
  // entry cycle. With noise, random crash levels are applied throughout.
  task automatic run_countdown(input bit noise);
    game_state = 3'd2;
    step();
    checks++;
    if (countdown !== 2'd3) begin
      errors++;
      $display("FAIL countdown_load got %0d want 3", countdown);
    end
    step();
    for (int d = 3; d >= 1; d--) begin
      for (int f = 0; f < COUNT; f++) begin
        if (noise) begin
          blue_crash = 1'($urandom_range(0, 1));
          red_crash  = 1'($urandom_range(0, 1));
        end
        repeat ($urandom_range(0, 2)) step();
        frame();
        checks++;
        if (countdown !== 2'((f == COUNT - 1) ? d - 1 : d)) begin
          errors++;
          $display("FAIL countdown_digit got %0d want %0d", countdown, (f == COUNT - 1) ? d - 1 : d);
        end
      end
    end
    blue_crash = 1'b0;
    red_crash  = 1'b0;
    exp_draw = 1'b0;
    checks++;
    if (round_draw !== exp_draw) begin
      errors++;
      $display("FAIL draw_clear_on_run got %0b want %0b", round_draw, exp_draw);
    end
    checks++;
    if (blue_score !== 4'(exp_blue) || red_score !== 4'(exp_red)) begin
      errors++;
      $display("FAIL countdown_scores got %0d/%0d want %0d/%0d", blue_score, red_score, exp_blue, exp_red);
    end
  endtask

  // n more frames in RUN; every TICK-th frame since entry must tick.
  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      int g;
      g = $urandom_range(0, 2);
      for (int i = 0; i < g; i++) begin
        step();
        checks++;
        if (move_tick !== 1'b0) begin
          errors++;
          $display("FAIL tick_gap got %0b want 0 (frame %0d)", move_tick, run_frames);
        end
      end
      frame();
      run_frames++;
      checks++;
      if (move_tick !== ((run_frames % TICK) == 0)) begin
        errors++;
        $display("FAIL tick_frame got %0b want %0b (frame %0d)", move_tick, (run_frames % TICK) == 0, run_frames);
      end
    end
  endtask

  // kind 0: blue crashes, 1: red crashes, 2: both. Then the hold and outcome.
  task automatic crash_and_hold(input int kind);
    int win_b, win_r;
    blue_crash = (kind == 0) || (kind == 2);
    red_crash  = (kind == 1) || (kind == 2);
    frame_start = 1'($urandom_range(0, 1));
    step();
    blue_crash = 1'b0;
    red_crash = 1'b0;
    frame_start = 1'b0;
    if (kind == 0) exp_red = (exp_red < 15) ? exp_red + 1 : 15;
    else if (kind == 1) exp_blue = (exp_blue < 15) ? exp_blue + 1 : 15;
    else exp_draw = 1'b1;
    checks++;
    if (move_tick !== 1'b0) begin
      errors++;
      $display("FAIL crash_no_tick got %0b want 0", move_tick);
    end
    checks++;
    if (blue_score !== 4'(exp_blue) || red_score !== 4'(exp_red) || round_draw !== exp_draw) begin
      errors++;
      $display("FAIL crash_score got %0d/%0d/%0b want %0d/%0d/%0b", blue_score, red_score, round_draw, exp_blue, exp_red, exp_draw);
    end
    step();
    for (int f = 1; f <= HOLD; f++) begin
      repeat ($urandom_range(0, 2)) step();
      frame();
      if (f < HOLD) begin
        checks++;
        if ({reset_round, clear_trails, blue_w, red_w} !== 4'd0) begin
          errors++;
          $display("FAIL hold_quiet got %b want 0000 (frame %0d)", {reset_round, clear_trails, blue_w, red_w}, f);
        end
      end
    end
    win_b = (exp_blue >= WIN) ? 1 : 0;
    win_r = (!win_b && exp_red >= WIN) ? 1 : 0;
    last_win = (win_b || win_r);
    checks++;
    if (blue_w !== 1'(win_b) || red_w !== 1'(win_r)) begin
      errors++;
      $display("FAIL hold_win got %0b/%0b want %0d/%0d", blue_w, red_w, win_b, win_r);
    end
    checks++;
    if (reset_round !== !last_win || clear_trails !== !last_win) begin
      errors++;
      $display("FAIL hold_teardown got %0b/%0b want %0b", reset_round, clear_trails, !last_win);
    end
    if (!last_win) begin
      game_state = 3'd1;
      step();
      checks++;
      if (reset_round !== 1'b0 || clear_trails !== 1'b0 || countdown !== 2'd0) begin
        errors++;
        $display("FAIL teardown_single got %0b/%0b/%0d want 0/0/0", reset_round, clear_trails, countdown);
      end
      checks++;
      if (round_draw !== exp_draw) begin
        errors++;
        $display("FAIL draw_held got %0b want %0b", round_draw, exp_draw);
      end
    end
  endtask

  task automatic test_ticks_and_red_crash();
    run_countdown(1'b0);
    step();
    run_frames = 0;
    run_ticks(12);
    crash_and_hold(1);
  endtask

  task automatic test_draw();
    run_countdown(1'b0);
    step();
    run_frames = 0;
    run_ticks($urandom_range(0, 6));
    crash_and_hold(2);
  endtask

  task automatic test_entry_frame();
    run_countdown(1'b1);
    frame();
    checks++;
    if (move_tick !== 1'b0) begin
      errors++;
      $display("FAIL entry_frame got %0b want 0", move_tick);
    end
    run_frames = 0;
    run_ticks(2 * TICK);
    crash_and_hold(2);
  endtask

  task automatic test_abort();
    run_countdown(1'b0);
    step();
    run_frames = 0;
    run_ticks(TICK + 1);
    game_state = 3'd1;
    step();
    checks++;
    if (move_tick !== 1'b0 || countdown !== 2'd0) begin
      errors++;
      $display("FAIL abort_next got %0b/%0d want 0/0", move_tick, countdown);
    end
    for (int f = 0; f < 2 * TICK; f++) begin
      frame();
      checks++;
      if (move_tick !== 1'b0 || reset_round !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet got %0b/%0b want 0/0", move_tick, reset_round);
      end
    end
    checks++;
    if (blue_score !== 4'(exp_blue) || red_score !== 4'(exp_red)) begin
      errors++;
      $display("FAIL abort_scores got %0d/%0d want %0d/%0d", blue_score, red_score, exp_blue, exp_red);
    end
  endtask

  task automatic test_match_win();
    int rounds = 0;
    last_win = 1'b0;
    while (!last_win && rounds < 20) begin
      int r;
      r = $urandom_range(0, 3);
      run_countdown(1'b0);
      step();
      run_frames = 0;
      run_ticks($urandom_range(0, 6));
      crash_and_hold((r == 3) ? 1 : r);
      rounds++;
    end
    checks++;
    if (!last_win) begin
      errors++;
      $display("FAIL match_no_winner got %0d/%0d want a winner", blue_score, red_score);
    end else begin
      bit wb;
      wb = (exp_blue >= WIN);
      repeat (3) begin
        frame();
        checks++;
        if (blue_w !== wb || red_w !== !wb || reset_round !== 1'b0) begin
          errors++;
          $display("FAIL report_hold got %0b/%0b/%0b want %0b/%0b/0", blue_w, red_w, reset_round, wb, !wb);
        end
      end
      game_state = wb ? 3'd3 : 3'd4;
      step();
      checks++;
      if (blue_w !== 1'b0 || red_w !== 1'b0) begin
        errors++;
        $display("FAIL report_release got %0b/%0b want 0/0", blue_w, red_w);
      end
      checks++;
      if (blue_score !== 4'(exp_blue) || red_score !== 4'(exp_red)) begin
        errors++;
        $display("FAIL report_scores got %0d/%0d want %0d/%0d", blue_score, red_score, exp_blue, exp_red);
      end
      game_state = 3'd0;
      step();
      exp_blue = 0;
      exp_red = 0;
      exp_draw = 1'b0;
      checks++;
      if (blue_score !== 4'd0 || red_score !== 4'd0 || round_draw !== 1'b0) begin
        errors++;
        $display("FAIL menu_clear got %0d/%0d/%0b want 0/0/0", blue_score, red_score, round_draw);
      end
      game_state = 3'd1;
      step();
    end
  endtask

  task automatic test_reset_game();
    run_countdown(1'b0);
    step();
    run_frames = 0;
    run_ticks(3);
    red_crash = 1'b1;
    step();
    red_crash = 1'b0;
    exp_blue++;
    checks++;
    if (blue_score !== 4'(exp_blue)) begin
      errors++;
      $display("FAIL rg_pre_score got %0d want %0d", blue_score, exp_blue);
    end
    step();
    frame();
    frame();
    game_state = 3'd1;
    reset_game = 1'b1;
    step();
    reset_game = 1'b0;
    exp_blue = 0;
    exp_red = 0;
    checks++;
    if ({move_tick, countdown, reset_round, clear_trails, blue_w, red_w, round_draw, blue_score, red_score} !== 16'd0) begin
      errors++;
      $display("FAIL reset_game_outputs got %h want 0", {move_tick, countdown, reset_round, clear_trails, blue_w, red_w, round_draw, blue_score, red_score});
    end
    for (int f = 0; f < HOLD + 2; f++) begin
      frame();
      checks++;
      if (reset_round !== 1'b0 || clear_trails !== 1'b0) begin
        errors++;
        $display("FAIL reset_game_quiet got %0b/%0b want 0/0", reset_round, clear_trails);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ticks_and_red_crash();
    test_draw();
    test_entry_frame();
    test_abort();
    test_match_win();
    test_reset_game();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
